ipm_distributed_sync_fifo: RTL and testbench



---
 rtl/ipm_distributed_sync_fifo_pkg.sv | 21 ++
 rtl/ipm_distributed_sync_fifo_core.sv | 26 ++
 rtl/ipm_distributed_sync_fifo.sv | 103 ++++++++++
 tb/tb_ipm_distributed_sync_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipm_distributed_sync_fifo_pkg.sv
// Shared sizing helpers and default thresholds for the distributed-RAM sync FIFO.
package ipm_distributed_sync_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH       = 4;
  localparam int unsigned DEF_DATA_WIDTH       = 16;
  localparam int unsigned DEF_ALMOST_EMPTY_NUM = 2;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 1;
  endfunction

  // Default almost-full level: two below full.
  function automatic int unsigned def_almost_full(input int unsigned aw);
    return fifo_depth(aw) - 2;
  endfunction

endpackage

// File: rtl/ipm_distributed_sync_fifo_core.sv
// Distributed simple-dual-port RAM: synchronous write, asynchronous read, no reset.
module dist_sdpram_core
  import ipm_distributed_sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ipm_distributed_sync_fifo.sv
// Single-clock FIFO on distributed RAM with registered read port, fill count,
// programmable almost flags and overflow/underflow pulses.
module ipm_distributed_sync_fifo
  import ipm_distributed_sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned ALMOST_FULL_NUM  = def_almost_full(ADDR_WIDTH),
  parameter int unsigned ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH);

  if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH ||
      ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_cfg
    $error("ipm_distributed_sync_fifo: ALMOST_* threshold out of range");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid, r_full, r_empty, r_afull, r_aempty;
  logic                  r_overflow, r_underflow;

  logic                  w_wr_acc, w_rd_acc;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_ram_rd;

  // A write is allowed into a full FIFO only when a read frees a slot at the same edge.
  assign w_wr_acc     = wr_en & (~r_full | rd_en);
  assign w_rd_acc     = rd_en & ~r_empty;
  assign w_count_next = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

  dist_sdpram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rd)
  );

  // Flags come from the next count so they line up with data_count every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
        r_rd_data <= w_ram_rd;
      end
      r_count     <= w_count_next;
      r_rd_valid  <= w_rd_acc;
      r_full      <= (w_count_next == CNT_W'(DEPTH));
      r_empty     <= (w_count_next == '0);
      r_afull     <= (w_count_next >= CNT_W'(ALMOST_FULL_NUM));
      r_aempty    <= (w_count_next <= CNT_W'(ALMOST_EMPTY_NUM));
      r_overflow  <= wr_en & ~w_wr_acc;
      r_underflow <= rd_en & ~w_rd_acc;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign data_count   = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_ipm_distributed_sync_fifo.sv
// Scoreboard bench for ipm_distributed_sync_fifo (16 x 16, AF=14, AE=2).
module tb_ipm_distributed_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0]  data_count;
  logic        overflow, underflow;

  int errors = 0;
  int checks = 0;

  // Scoreboard / model state
  logic [15:0] m_q[$];
  int          m_count = 0;
  logic [15:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  ipm_distributed_sync_fifo #(
    .ADDR_WIDTH       (4),
    .DATA_WIDTH       (16),
    .ALMOST_FULL_NUM  (14),
    .ALMOST_EMPTY_NUM (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, update the model, and land 1 time unit after the edge.
  task automatic step(input logic w, input logic [15:0] d, input logic r);
    logic wa, ra;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    wa = w && (m_count != 16 || r);
    ra = r && (m_count != 0);
    m_ovf      = w && !wa;
    m_unf      = r && !ra;
    m_rd_valid = ra;
    if (ra) m_rd_data = m_q.pop_front();
    if (wa) m_q.push_back(d);
    m_count = m_q.size();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({data_count, empty, almost_empty, full, almost_full} !== {5'd0, 4'b1100}) begin
      errors++;
      $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b, want cnt=0 e=1 ae=1 f=0 af=0",
               data_count, empty, almost_empty, full, almost_full);
    end
    checks++;
    if ({rd_data, rd_valid, overflow, underflow} !== {16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h v=%b ov=%b un=%b, want all zero",
               rd_data, rd_valid, overflow, underflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_writes();
    for (int unsigned i = 1; i <= 3; i++) begin
      step(1'b1, 16'(i), 1'b0);
      checks++;
      if (data_count !== 5'(i)) begin
        errors++;
        $display("FAIL first_write_count: got %0d want %0d", data_count, i);
      end
      checks++;
      if (empty !== 1'b0) begin
        errors++;
        $display("FAIL first_write_empty: got %b want 0 at count %0d", empty, i);
      end
      checks++;
      if (almost_empty !== (i <= 2)) begin
        errors++;
        $display("FAIL first_write_aempty: got %b want %b at count %0d", almost_empty, (i <= 2), i);
      end
    end
  endtask

  task automatic test_fill_and_overflow();
    for (int unsigned i = 4; i <= 16; i++) begin
      step(1'b1, 16'(i), 1'b0);
      checks++;
      if ({data_count, almost_full, full} !== {5'(i), (i >= 14), (i == 16)}) begin
        errors++;
        $display("FAIL fill_flags: got cnt=%0d af=%b f=%b want cnt=%0d af=%b f=%b",
                 data_count, almost_full, full, i, (i >= 14), (i == 16));
      end
    end
    step(1'b1, 16'hDEAD, 1'b0);
    checks++;
    if ({overflow, data_count, full} !== {m_ovf, 5'(m_count), 1'b1} || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse: got ov=%b cnt=%0d f=%b want ov=1 cnt=16 f=1",
               overflow, data_count, full);
    end
    step(1'b0, 16'h0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_single: got ov=%b want 0", overflow);
    end
  endtask

  task automatic test_full_rw();
    step(1'b1, 16'hBEEF, 1'b1);
    checks++;
    if ({rd_data, rd_valid, data_count, full, overflow} !== {16'h0001, 1'b1, 5'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_rw: got rd=%h v=%b cnt=%0d f=%b ov=%b want rd=0001 v=1 cnt=16 f=1 ov=0",
               rd_data, rd_valid, data_count, full, overflow);
    end
  endtask

  task automatic test_drain_and_underflow();
    logic [15:0] held;
    for (int unsigned i = 1; i <= 16; i++) begin
      step(1'b0, 16'h0, 1'b1);
      checks++;
      if ({rd_valid, rd_data, data_count} !== {1'b1, m_rd_data, 5'(m_count)}) begin
        errors++;
        $display("FAIL drain_%0d: got v=%b rd=%h cnt=%0d want v=1 rd=%h cnt=%0d",
                 i, rd_valid, rd_data, data_count, m_rd_data, m_count);
      end
    end
    checks++;
    if ({rd_data, empty, almost_empty} !== {16'hBEEF, 2'b11}) begin
      errors++;
      $display("FAIL drain_last: got rd=%h e=%b ae=%b want rd=beef e=1 ae=1",
               rd_data, empty, almost_empty);
    end
    held = m_rd_data;
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if ({underflow, rd_valid, rd_data, data_count} !== {1'b1, 1'b0, held, 5'd0}) begin
      errors++;
      $display("FAIL underflow: got un=%b v=%b rd=%h cnt=%0d want un=1 v=0 rd=%h cnt=0",
               underflow, rd_valid, rd_data, data_count, held);
    end
    step(1'b1, 16'h1234, 1'b1);
    checks++;
    if ({underflow, rd_valid, data_count, empty} !== {1'b1, 1'b0, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL empty_rw: got un=%b v=%b cnt=%0d e=%b want un=1 v=0 cnt=1 e=0",
               underflow, rd_valid, data_count, empty);
    end
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if ({rd_valid, rd_data, underflow} !== {1'b1, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL empty_rw_readback: got v=%b rd=%h un=%b want v=1 rd=1234 un=0",
               rd_valid, rd_data, underflow);
    end
  endtask

  task automatic test_wrap();
    int unsigned written = 0;
    int unsigned guard = 0;
    logic w, r;
    while ((written < 40 || m_count != 0) && guard < 400) begin
      guard++;
      w = (written < 40) && ($urandom_range(0, 3) != 0);
      r = (written >= 40) || ($urandom_range(0, 2) == 0);
      if (w && !(m_count != 16 || r)) w = 1'b0;
      if (w) written++;
      step(w, 16'($urandom), r);
      checks++;
      if ({data_count, empty, full, rd_valid, overflow, underflow} !==
          {5'(m_count), (m_count == 0), (m_count == 16), m_rd_valid, m_ovf, m_unf}) begin
        errors++;
        $display("FAIL wrap_status: got cnt=%0d e=%b f=%b v=%b ov=%b un=%b want cnt=%0d e=%b f=%b v=%b ov=%b un=%b",
                 data_count, empty, full, rd_valid, overflow, underflow,
                 m_count, (m_count == 0), (m_count == 16), m_rd_valid, m_ovf, m_unf);
      end
      if (m_rd_valid) begin
        checks++;
        if (rd_data !== m_rd_data) begin
          errors++;
          $display("FAIL wrap_data: got %h want %h", rd_data, m_rd_data);
        end
      end
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL wrap_budget: got %0d cycles, required under 400", guard);
    end
  endtask

  task automatic test_async_reset();
    for (int unsigned i = 0; i < 9; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'hA009, 1'b0);
    checks++;
    if (data_count !== 5'd9) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 9", data_count);
    end
    #3;
    rst = 1'b1;
    #1;
    m_q.delete();
    m_count   = 0;
    m_rd_data = '0;
    checks++;
    if ({data_count, empty, almost_empty, full, almost_full, rd_data, rd_valid, overflow, underflow}
        !== {5'd0, 4'b1100, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d e=%b ae=%b f=%b af=%b rd=%h v=%b ov=%b un=%b want reset values",
               data_count, empty, almost_empty, full, almost_full, rd_data, rd_valid, overflow, underflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 16'h5A5A, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if ({rd_valid, rd_data, data_count} !== {1'b1, 16'h5A5A, 5'd0}) begin
      errors++;
      $display("FAIL post_reset_readback: got v=%b rd=%h cnt=%0d want v=1 rd=5a5a cnt=0",
               rd_valid, rd_data, data_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_writes();
    test_fill_and_overflow();
    test_full_rw();
    test_drain_and_underflow();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
